// File: rtl/request_manager_pkg.sv
// Shared elevator definitions: floor count default and the travel direction
// encoding, which matches the state controller's ud_mode.
package elevator_pkg;

    localparam int NFLOORS_DEFAULT = 4;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DN   = 2'b10
    } dir_e;

endpackage

// File: rtl/request_manager_if.sv
// Button inputs, car feedback and request/direction outputs of the request
// manager. The master side is the environment (panels + state controller).
interface request_manager_if
    import elevator_pkg::*;
#(
    parameter int NFLOORS = NFLOORS_DEFAULT
);
    logic [NFLOORS-1:0] car_btn;
    logic [NFLOORS-1:0] hall_up_btn;
    logic [NFLOORS-1:0] hall_dn_btn;
    logic [NFLOORS-1:0] position;
    logic               opendoor;

    logic [NFLOORS-1:0] allReq_reg;
    logic               up_need;
    logic               down_need;
    logic [NFLOORS-1:0] car_req;
    logic [NFLOORS-1:0] hall_up_req;
    logic [NFLOORS-1:0] hall_dn_req;
    logic [1:0]         dir;
    logic               pos_err;

    modport master (
        output car_btn, hall_up_btn, hall_dn_btn, position, opendoor,
        input  allReq_reg, up_need, down_need, car_req, hall_up_req,
               hall_dn_req, dir, pos_err
    );

    modport slave (
        input  car_btn, hall_up_btn, hall_dn_btn, position, opendoor,
        output allReq_reg, up_need, down_need, car_req, hall_up_req,
               hall_dn_req, dir, pos_err
    );
endinterface

// File: rtl/request_manager_btn_edge_sync.sv
// Multi-flop synchroniser followed by a rising-edge detector. The history
// flop resets to 0, so a button held through reset reads as one fresh press.
module btn_edge_sync #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);
    logic [DEPTH-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]            hist_q, hist_d;

    // shift the raw level down the synchroniser chain; history trails the last stage
    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], din};
        hist_d = sync_q[DEPTH-1];
    end

    // synchroniser and history registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[DEPTH-1] & ~hist_q;
endmodule

// File: rtl/request_manager.sv
// Latches car/hall calls, clears them as floors are served and keeps a
// registered travel direction for the elevator state controller.
//
// dir state | meaning
// ----------+----------------------------------------------------------
// DIR_IDLE  | no call above or below; up/down first found wins (up first)
// DIR_UP    | travelling up; keep going while calls remain above
// DIR_DN    | travelling down; keep going while calls remain below
module request_manager
    import elevator_pkg::*;
#(
    parameter int NFLOORS     = NFLOORS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              switch,
    request_manager_if.slave bus
);
    localparam logic [NFLOORS-1:0] HUP_MASK = {1'b0, {(NFLOORS-1){1'b1}}};
    localparam logic [NFLOORS-1:0] HDN_MASK = {{(NFLOORS-1){1'b1}}, 1'b0};

    logic [NFLOORS-1:0] car_rise, hup_rise, hdn_rise;
    logic [NFLOORS-1:0] car_req_q, car_req_d;
    logic [NFLOORS-1:0] hall_up_req_q, hall_up_req_d;
    logic [NFLOORS-1:0] hall_dn_req_q, hall_dn_req_d;
    dir_e               dir_q, dir_d;
    logic               up_need_q, up_need_d;
    logic               down_need_q, down_need_d;
    logic               pos_err_q, pos_err_d;

    logic [NFLOORS-1:0] all_req, below_mask, above_mask;
    logic [NFLOORS-1:0] car_clr, hup_clr, hdn_clr;
    logic               pos_bad, serve, req_above, req_below;

    btn_edge_sync #(.WIDTH(NFLOORS), .DEPTH(SYNC_STAGES)) u_car_sync (
        .clk(clk), .rst_b(switch), .din(bus.car_btn), .rise(car_rise));
    btn_edge_sync #(.WIDTH(NFLOORS), .DEPTH(SYNC_STAGES)) u_hup_sync (
        .clk(clk), .rst_b(switch), .din(bus.hall_up_btn), .rise(hup_rise));
    btn_edge_sync #(.WIDTH(NFLOORS), .DEPTH(SYNC_STAGES)) u_hdn_sync (
        .clk(clk), .rst_b(switch), .din(bus.hall_dn_btn), .rise(hdn_rise));

    // split pending calls into above/below the car; the current floor counts as neither
    always_comb begin
        all_req    = car_req_q | hall_up_req_q | hall_dn_req_q;
        pos_bad    = !$onehot(bus.position);
        below_mask = bus.position - NFLOORS'(1);
        above_mask = ~(below_mask | bus.position);
        req_above  = |(all_req & above_mask);
        req_below  = |(all_req & below_mask);
    end

    // serve the current floor: hall calls only clear in the direction we will leave in
    always_comb begin
        serve   = bus.opendoor && !pos_bad;
        car_clr = serve ? bus.position : '0;
        hup_clr = (serve && (dir_q != DIR_DN || bus.position[NFLOORS-1])) ? bus.position : '0;
        hdn_clr = (serve && (dir_q != DIR_UP || bus.position[0])) ? bus.position : '0;

        car_req_d     = (car_req_q | car_rise) & ~car_clr;
        hall_up_req_d = (hall_up_req_q | (hup_rise & HUP_MASK)) & ~hup_clr & HUP_MASK;
        hall_dn_req_d = (hall_dn_req_q | (hdn_rise & HDN_MASK)) & ~hdn_clr & HDN_MASK;
    end

    // direction next-state: hold while the door is open, idle on a bad position
    always_comb begin
        dir_d = dir_q;
        if (pos_bad) begin
            dir_d = DIR_IDLE;
        end else if (!bus.opendoor) begin
            case (dir_q)
                DIR_UP:  dir_d = req_above ? DIR_UP : (req_below ? DIR_DN : DIR_IDLE);
                DIR_DN:  dir_d = req_below ? DIR_DN : (req_above ? DIR_UP : DIR_IDLE);
                default: dir_d = req_above ? DIR_UP : (req_below ? DIR_DN : DIR_IDLE);
            endcase
        end
        up_need_d   = (dir_d == DIR_UP);
        down_need_d = (dir_d == DIR_DN);
        pos_err_d   = pos_bad;
    end

    // request, direction and status registers, cleared by the master switch
    always_ff @(posedge clk) begin
        if (!switch) begin
            car_req_q     <= '0;
            hall_up_req_q <= '0;
            hall_dn_req_q <= '0;
            dir_q         <= DIR_IDLE;
            up_need_q     <= 1'b0;
            down_need_q   <= 1'b0;
            pos_err_q     <= 1'b0;
        end else begin
            car_req_q     <= car_req_d;
            hall_up_req_q <= hall_up_req_d;
            hall_dn_req_q <= hall_dn_req_d;
            dir_q         <= dir_d;
            up_need_q     <= up_need_d;
            down_need_q   <= down_need_d;
            pos_err_q     <= pos_err_d;
        end
    end

    assign bus.allReq_reg  = all_req;
    assign bus.car_req     = car_req_q;
    assign bus.hall_up_req = hall_up_req_q;
    assign bus.hall_dn_req = hall_dn_req_q;
    assign bus.dir         = dir_q;
    assign bus.up_need     = up_need_q;
    assign bus.down_need   = down_need_q;
    assign bus.pos_err     = pos_err_q;
endmodule

// File: tb/tb_request_manager.sv
// Directed bench for request_manager: expected values are hand-computed per step.
module tb_request_manager;
    logic clk;
    logic sw;
    int   errors = 0;
    int   checks = 0;

    request_manager_if bus_if ();

    request_manager dut (
        .clk   (clk),
        .switch(sw),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // test 1: button held through reset is latched once after release
        sw = 1'b0;
        bus_if.car_btn     = 4'b0010;
        bus_if.hall_up_btn = 4'b0000;
        bus_if.hall_dn_btn = 4'b0000;
        bus_if.position    = 4'b0001;
        bus_if.opendoor    = 1'b0;
        tick(2);
        check("rst_car_req", bus_if.car_req, 4'b0000);
        check("rst_allreq",  bus_if.allReq_reg, 4'b0000);
        check("rst_dir",     4'(bus_if.dir), 4'b0000);
        check("rst_up_need", 4'(bus_if.up_need), 4'd0);
        check("rst_pos_err", 4'(bus_if.pos_err), 4'd0);
        sw = 1'b1;
        tick(2);
        check("t1_car_req_e2", bus_if.car_req, 4'b0000);
        tick(1);
        check("t1_car_req_e3", bus_if.car_req, 4'b0010);
        check("t1_allreq_e3",  bus_if.allReq_reg, 4'b0010);
        check("t1_up_need_e3", 4'(bus_if.up_need), 4'd0);
        tick(1);
        check("t1_dir",       4'(bus_if.dir), 4'b0001);
        check("t1_up_need",   4'(bus_if.up_need), 4'd1);
        check("t1_down_need", 4'(bus_if.down_need), 4'd0);
        tick(3);
        check("t1_hold_once", bus_if.car_req, 4'b0010);
        bus_if.car_btn = 4'b0000;

        // test 5: serve floor 1, then a press there with the door open is absorbed
        bus_if.position = 4'b0010;
        bus_if.opendoor = 1'b1;
        tick(1);
        check("t5_served", bus_if.car_req, 4'b0000);
        check("t5_dir_hold", 4'(bus_if.dir), 4'b0001);
        bus_if.car_btn = 4'b0010;
        tick(1);
        bus_if.car_btn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t5_absorbed", bus_if.car_req, 4'b0000);
        end
        bus_if.opendoor = 1'b0;
        tick(1);
        check("t5_idle", 4'(bus_if.dir), 4'b0000);
        check("t5_up_need", 4'(bus_if.up_need), 4'd0);

        // test 3: calls above and below; up holds until the top call is served
        bus_if.car_btn = 4'b1001;
        tick(1);
        bus_if.car_btn = 4'b0000;
        tick(2);
        check("t3_car_req", bus_if.car_req, 4'b1001);
        check("t3_dir_pre", 4'(bus_if.dir), 4'b0000);
        tick(1);
        check("t3_dir_up", 4'(bus_if.dir), 4'b0001);
        check("t3_up_need", 4'(bus_if.up_need), 4'd1);
        bus_if.position = 4'b0100;
        tick(2);
        check("t3_still_up", 4'(bus_if.up_need), 4'd1);
        bus_if.position = 4'b1000;
        bus_if.opendoor = 1'b1;
        tick(1);
        check("t3_top_clr", bus_if.car_req, 4'b0001);
        check("t3_dir_door", 4'(bus_if.dir), 4'b0001);
        bus_if.opendoor = 1'b0;
        tick(1);
        check("t3_dir_dn", 4'(bus_if.dir), 4'b0010);
        check("t3_down_need", 4'(bus_if.down_need), 4'd1);
        check("t3_up_need0", 4'(bus_if.up_need), 4'd0);

        // return to idle: serve floor 0
        bus_if.position = 4'b0001;
        bus_if.opendoor = 1'b1;
        tick(1);
        bus_if.opendoor = 1'b0;
        tick(1);
        check("idle_a", 4'(bus_if.dir), 4'b0000);

        // test 2: hall down at floor 0 ignored, car call below -> down
        bus_if.position    = 4'b0100;
        bus_if.hall_dn_btn = 4'b0001;
        bus_if.car_btn     = 4'b0001;
        tick(1);
        bus_if.hall_dn_btn = 4'b0000;
        bus_if.car_btn     = 4'b0000;
        tick(2);
        check("t2_allreq", bus_if.allReq_reg, 4'b0001);
        check("t2_hall_dn", bus_if.hall_dn_req, 4'b0000);
        tick(1);
        check("t2_down_need", 4'(bus_if.down_need), 4'd1);
        check("t2_up_need", 4'(bus_if.up_need), 4'd0);
        check("t2_dir", 4'(bus_if.dir), 4'b0010);

        bus_if.position = 4'b0001;
        bus_if.opendoor = 1'b1;
        tick(1);
        bus_if.opendoor = 1'b0;
        tick(1);
        check("idle_b", 4'(bus_if.dir), 4'b0000);

        // test 4: going up at floor 2, only the up hall call there is served
        bus_if.position    = 4'b0010;
        bus_if.car_btn     = 4'b1000;
        bus_if.hall_up_btn = 4'b1100;
        bus_if.hall_dn_btn = 4'b0100;
        tick(1);
        bus_if.car_btn     = 4'b0000;
        bus_if.hall_up_btn = 4'b0000;
        bus_if.hall_dn_btn = 4'b0000;
        tick(2);
        check("t4_hall_up", bus_if.hall_up_req, 4'b0100);
        check("t4_hall_dn", bus_if.hall_dn_req, 4'b0100);
        check("t4_allreq", bus_if.allReq_reg, 4'b1100);
        tick(1);
        check("t4_dir_up", 4'(bus_if.dir), 4'b0001);
        bus_if.position = 4'b0100;
        bus_if.opendoor = 1'b1;
        tick(1);
        check("t4_up_clr", bus_if.hall_up_req, 4'b0000);
        check("t4_dn_keep", bus_if.hall_dn_req, 4'b0100);
        check("t4_car_keep", bus_if.car_req, 4'b1000);

        // test 6: non-one-hot position
        bus_if.opendoor = 1'b0;
        bus_if.position = 4'b0110;
        tick(1);
        check("t6_pos_err", 4'(bus_if.pos_err), 4'd1);
        check("t6_dir", 4'(bus_if.dir), 4'b0000);
        check("t6_up_need", 4'(bus_if.up_need), 4'd0);
        check("t6_down_need", 4'(bus_if.down_need), 4'd0);
        check("t6_reqs_kept", bus_if.allReq_reg, 4'b1100);
        bus_if.position = 4'b0100;
        tick(1);
        check("t6_pos_ok", 4'(bus_if.pos_err), 4'd0);
        check("t6_dir_up", 4'(bus_if.dir), 4'b0001);
        check("t6_up_need1", 4'(bus_if.up_need), 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/request_manager.md
Name: request_manager

Overview:
- Upstream stage of the elevator state controller.
- Synchronises and edge-detects car and hall call buttons, latches them as pending requests, and clears requests as they are served.
- Drives the controller's `allReq_reg`, `up_need` and `down_need` inputs.
- Keeps a registered travel direction so that `up_need`/`down_need` do not flip-flop while calls remain ahead of the car.

Parameters:
- NFLOORS, 4, number of floors; all floor vectors are one-hot/bitmask, bit 0 = ground floor.
- SYNC_STAGES, 2, synchroniser depth for button inputs (minimum 2).

Ports:
- clk  input  1  system clock (32 Hz controller clock).
- switch  input  1  elevator master switch; synchronous active-low reset, sampled on posedge clk.
- car_btn  input  NFLOORS  in-car floor buttons, level, asynchronous.
- hall_up_btn  input  NFLOORS  hall up buttons; bit NFLOORS-1 ignored.
- hall_dn_btn  input  NFLOORS  hall down buttons; bit 0 ignored.
- position  input  NFLOORS  current floor, one-hot, from the state controller.
- opendoor  input  1  door-open command from the state controller.
- allReq_reg  output  NFLOORS  pending stop mask = car_req | hall_up_req | hall_dn_req (combinational OR of registers).
- up_need  output  1  registered; a request exists above and upward travel is chosen.
- down_need  output  1  registered; a request exists below and downward travel is chosen.
- car_req  output  NFLOORS  latched car calls (lamp drive).
- hall_up_req  output  NFLOORS  latched hall up calls; bit NFLOORS-1 is always 0.
- hall_dn_req  output  NFLOORS  latched hall down calls; bit 0 is always 0.
- dir  output  2  registered direction: 00 idle, 01 up, 10 down (same encoding as ud_mode).
- pos_err  output  1  registered; position is not one-hot.

Behaviour:
Reset (switch=0 at posedge):
- All request registers, synchroniser flops, edge-history flops, dir, up_need, down_need and pos_err go to 0.
- A button held through reset release is treated as a fresh press and latched once.

Button path:
- SYNC_STAGES-flop synchroniser, then rising-edge detect against a history flop.
- With SYNC_STAGES=2, a button going high before edge k sets its request bit at edge k+2.
- It becomes visible on allReq_reg after that edge; up_need/down_need follow one edge later.
- Holding a button produces a single latch. Re-pressing an already pending call has no effect.

Serve/clear (evaluated every cycle while opendoor=1, at floor f = position):
- car_req[f] is cleared.
- hall_up_req[f] is cleared if dir is up or idle, or if f is the top floor.
- hall_dn_req[f] is cleared if dir is down or idle, or if f = 0.
- Same-cycle press and clear of the same bit: clear wins. A call at the current floor made while the door is open is absorbed.

Direction register (next-state from current requests R = allReq_reg; above = R bits above position, below = R bits below):
- idle: above≠0 → up; else below≠0 → down; else stay idle.
- up: above≠0 → stay up; else below≠0 → down; else idle.
- down: below≠0 → stay down; else above≠0 → up; else idle.
- Direction changes only while opendoor=0. While the door is open, dir holds.

Needs and position error:
- up_need ← (dir_next==up); down_need ← (dir_next==down). The two are mutually exclusive.
- pos_err ← position not one-hot. While pos_err=1: no clears occur, dir is forced idle, needs are 0, requests still latch.
- Requests at the current floor contribute to neither above nor below.

Decomposition:
- Package elevator_pkg: NFLOORS default; direction constants DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DN=2'b10 (shared with the state controller's ud_mode).
- Sub-module btn_edge_sync: parameterised width/depth synchroniser plus rising-edge detector. It is instantiated three times (car, hall up, hall down).

Test Plan:
1. Reset with car_btn=0010 held, then switch=1 → car_req=0010 at third edge after release; with position=0001, dir=01 and up_need=1 one edge later.
2. position=0100, dir=idle, hall_dn_btn[0] ignored and car_btn=0001 pulsed → allReq_reg=0001, down_need=1, up_need=0.
3. dir=up, position=0010, car_req=1000 and hall_dn_req[0]... i.e. car call below at 0001 → up_need stays 1 until car_req=1000 cleared at position=1000 with opendoor=1; then dir=down, down_need=1.
4. position=0100, dir=up, hall_up_req[2]=1 and hall_dn_req[2]=1, opendoor=1 → only hall_up_req[2] cleared; hall_dn_req[2] remains.
5. opendoor=1 at position=0010 while car_btn=0010 pressed → car_req[1] never observed set.
6. position=0110 → pos_err=1 next edge, up_need=down_need=0, dir=00; restoring 0100 clears pos_err next edge.
